clock_div_prog: RTL and testbench
=================================

# clock_div_prog

Parametrised, multi-channel programmable clock divider generating NUM_CH divided clocks from the 26 MHz board clock. It is the successor to the fixed 26 MHz-to-1 MHz divider and serves the sensor, telemetry and timer logic.
- Each channel has a runtime-loadable divisor, glitch-free divisor changes at period boundaries, a per-channel enable, and a one-cycle tick strobe.
- A global SYNC input phase-aligns all channels.

## Interface
Parameters:
- CNT_WIDTH, 17, width of each channel's divisor and counter.
- NUM_CH, 2, number of independent output channels.
- DEFAULT_DIV, 26, divisor loaded into every channel at reset; must be at least 2.

Ports:
- CLK_IN  in  1  26 MHz source clock; all logic on its rising edge.
- RESET  in  1  reset, synchronous and active-low; sampled on CLK_IN.
- EN  in  NUM_CH  per-channel run enable.
- SYNC  in  1  global phase-align pulse.
- DIV_IN  in  NUM_CH*CNT_WIDTH  divisor values; channel i uses slice [i*CNT_WIDTH +: CNT_WIDTH].
- DIV_LOAD  in  NUM_CH  per-channel divisor load strobe.
- CLK_OUT  out  NUM_CH  divided clocks, registered.
- TICK_OUT  out  NUM_CH  one-cycle pulse at the start of each output period, registered.

## Operation
Per-channel registers: cnt, div_act, div_pend, pend_valid, clk_q, tick_q.

Reset (RESET=0 at a clock edge):
- div_act=DEFAULT_DIV, cnt=DEFAULT_DIV-1, pend_valid=0.
- CLK_OUT=0, TICK_OUT=0 for all channels.

Divisor rules:
- D = max(div_act, 2). Values 0 and 1 are clamped to 2.
- H = ceil(D/2). Output is high for H cycles and low for D-H cycles.
- D=26 gives 13 high / 13 low, i.e. 1 MHz.
- Odd D gives a high phase one cycle longer than the low phase.

Disabled channel (EN[i]=0):
- cnt forced to D-1, CLK_OUT[i]=0, TICK_OUT[i]=0.
- DIV_LOAD is still accepted into div_pend.

Enabled channel, evaluated each cycle; the wrap condition is `cnt==D-1 or SYNC=1`:
- On wrap:
  - cnt goes to 0.
  - If pend_valid, div_act takes div_pend and pend_valid clears.
  - clk_q goes to 1 and tick_q goes to 1.
- Otherwise:
  - cnt increments.
  - clk_q = (cnt+1 < H).
  - tick_q = 0.

Divisor loading:
- DIV_LOAD[i]=1 sets div_pend to the DIV_IN slice and sets pend_valid.
- A load never alters the current period.
- If DIV_LOAD[i] and a wrap occur in the same cycle, the DIV_IN value is applied directly as the new div_act (bypass) and pend_valid ends at 0.
- Multiple loads within one period: the last one wins.

SYNC:
- Forces a wrap on every enabled channel in the same cycle, so all enabled channels' CLK_OUT rise together.
- Disabled channels ignore SYNC.

Channels are fully independent apart from SYNC and RESET.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Enable latency: EN[i] rising, sampled at edge k, makes CLK_OUT[i]=1 and TICK_OUT[i]=1 after edge k.
- Reset release: with EN=1, the first edge at which RESET=1 produces a rising CLK_OUT and a TICK_OUT pulse.
- SYNC sampled at edge k: CLK_OUT=1 and TICK_OUT=1 after edge k on every enabled channel.
- Period is D cycles between TICK_OUT pulses. TICK_OUT is coincident with the CLK_OUT rising edge.
- Divisor change takes effect at the first wrap after the load.
  - No runt pulses: every high phase is H_old or H_new cycles long.
  - Every low phase is complete, except when a SYNC or disable cuts it short.
- Reset mid-operation: takes effect at the next edge. Pending loads are discarded.
- EN falling mid-period: CLK_OUT=0 after the next edge. The truncated period is accepted.

## Test plan
- Reset, then EN=2'b11 with defaults -> both CLK_OUT: 13 high, 13 low, period 26. TICK_OUT pulses every 26 cycles. First rise one edge after reset release.
- DIV_LOAD ch0 with 5 at cnt=7 -> current 26-cycle period completes unchanged. Following periods: 3 high, 2 low, tick every 5 cycles.
- DIV_IN=0, then 1, loaded to ch1 -> both behave as D=2: 1 high, 1 low, tick every 2 cycles.
- ch0 D=4, ch1 D=7, running out of phase; SYNC pulse -> both rise on the same edge after SYNC and both tick. Periods 4 and 7 resume from that edge.
- DIV_LOAD coincident with the wrap cycle (D 26 -> 10) -> the period starting at that wrap is 10 cycles (5/5), and pend_valid=0 afterwards.
- RESET asserted mid-high-phase with a pending load -> CLK_OUT=0, TICK_OUT=0 after the next edge. After release the period is DEFAULT_DIV (26) and the pending value is lost. EN=0 -> CLK_OUT held 0 and SYNC ignored.

Source files
------------

// File: rtl/clock_div_prog_if.sv
// Control/status bundle for the programmable multi-channel clock divider.
// The master drives enables, sync and divisor loads; the slave returns the divided clocks and ticks.
interface clock_div_prog_if #(
  parameter int NUM_CH    = 2,
  parameter int CNT_WIDTH = 17
) ();
  logic [NUM_CH-1:0]           en;
  logic                        sync;
  logic [NUM_CH*CNT_WIDTH-1:0] div_in;
  logic [NUM_CH-1:0]           div_load;
  logic [NUM_CH-1:0]           clk_out;
  logic [NUM_CH-1:0]           tick_out;

  modport master (
    output en, sync, div_in, div_load,
    input  clk_out, tick_out
  );

  modport slave (
    input  en, sync, div_in, div_load,
    output clk_out, tick_out
  );
endinterface

// File: rtl/clock_div_prog.sv
// NUM_CH independent programmable dividers off the 26 MHz board clock, with
// period-boundary divisor updates, per-channel enable and a global phase-align sync.
module clock_div_prog #(
  parameter int CNT_WIDTH   = 17,
  parameter int NUM_CH      = 2,
  parameter int DEFAULT_DIV = 26
) (
  input  logic             clk_in,
  input  logic             reset,
  clock_div_prog_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] DIV_MIN = CNT_WIDTH'(2);

  logic [NUM_CH-1:0] clk_vec;
  logic [NUM_CH-1:0] tick_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] div_act;
    logic [CNT_WIDTH-1:0] div_pend;
    logic [CNT_WIDTH-1:0] div_new;
    logic [CNT_WIDTH-1:0] d;
    logic [CNT_WIDTH-1:0] d_m1;
    logic [CNT_WIDTH:0]   h;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic                 pend_valid;
    logic                 clk_q;
    logic                 tick_q;
    logic                 load;
    logic                 wrap;

    assign div_new = bus.div_in[i*CNT_WIDTH +: CNT_WIDTH];
    assign load    = bus.div_load[i];
    // Divisors below 2 cannot produce both a high and a low phase.
    assign d       = (div_act < DIV_MIN) ? DIV_MIN : div_act;
    assign d_m1    = d - 1'b1;
    assign h       = ({1'b0, d} + 1'b1) >> 1;
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign wrap    = (cnt == d_m1) || bus.sync;

    always_ff @(posedge clk_in) begin
      if (!reset) begin
        cnt        <= DIV_RST - 1'b1;
        div_act    <= DIV_RST;
        div_pend   <= DIV_RST;
        pend_valid <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else if (!bus.en[i]) begin
        // Parking at D-1 makes the enabling edge start a fresh period.
        cnt    <= d_m1;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        if (load) begin
          div_pend   <= div_new;
          pend_valid <= 1'b1;
        end
      end else if (wrap) begin
        cnt    <= '0;
        clk_q  <= 1'b1;
        tick_q <= 1'b1;
        if (load) begin
          div_act    <= div_new;
          pend_valid <= 1'b0;
        end else if (pend_valid) begin
          div_act    <= div_pend;
          pend_valid <= 1'b0;
        end
      end else begin
        cnt    <= cnt + 1'b1;
        clk_q  <= (cnt_inc < h);
        tick_q <= 1'b0;
        if (load) begin
          div_pend   <= div_new;
          pend_valid <= 1'b1;
        end
      end
    end

    assign clk_vec[i]  = clk_q;
    assign tick_vec[i] = tick_q;
  end

  assign bus.clk_out  = clk_vec;
  assign bus.tick_out = tick_vec;

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed bench for clock_div_prog: two channels, default divisor 26.
// Inputs change and outputs are sampled on the falling edge.
module tb_clock_div_prog;
  localparam int NUM_CH = 2;
  localparam int CW     = 17;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  clock_div_prog_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW)) bus ();

  clock_div_prog #(.CNT_WIDTH(CW), .NUM_CH(NUM_CH), .DEFAULT_DIV(26)) dut (
    .clk_in (clk),
    .reset  (reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.en       = '0;
    bus.sync     = 1'b0;
    bus.div_load = '0;
    bus.div_in   = '0;
    step();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.clk_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_clk: got %b expected %b", bus.clk_out, 2'b00);
    end
    checks++;
    if (bus.tick_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_tick: got %b expected %b", bus.tick_out, 2'b00);
    end
    bus.en = 2'b11;
    step();
    checks++;
    if (bus.clk_out !== 2'b00 || bus.tick_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold_en: got clk %b tick %b expected 00 00", bus.clk_out, bus.tick_out);
    end
  endtask

  task automatic test_default();
    logic [1:0] exp_clk, exp_tick;
    do_reset();
    reset_n = 1'b1;
    bus.en  = 2'b11;
    for (int k = 0; k < 53; k++) begin
      step();
      exp_clk  = ((k % 26) < 13) ? 2'b11 : 2'b00;
      exp_tick = ((k % 26) == 0) ? 2'b11 : 2'b00;
      checks++;
      if (bus.clk_out !== exp_clk || bus.tick_out !== exp_tick) begin
        errors++;
        $display("FAIL default_div26 k=%0d: got clk %b tick %b expected clk %b tick %b",
                 k, bus.clk_out, bus.tick_out, exp_clk, exp_tick);
      end
    end
  endtask

  task automatic test_load_midperiod();
    logic [1:0] exp_clk, exp_tick;
    do_reset();
    reset_n = 1'b1;
    bus.en  = 2'b01;
    for (int k = 0; k < 46; k++) begin
      if (k == 8) begin
        bus.div_load        = 2'b01;
        bus.div_in[0 +: CW] = 17'd5;
      end else begin
        bus.div_load = 2'b00;
      end
      step();
      if (k < 26) begin
        exp_clk  = {1'b0, (k < 13)};
        exp_tick = {1'b0, (k == 0)};
      end else begin
        exp_clk  = {1'b0, (((k - 26) % 5) < 3)};
        exp_tick = {1'b0, (((k - 26) % 5) == 0)};
      end
      checks++;
      if (bus.clk_out !== exp_clk || bus.tick_out !== exp_tick) begin
        errors++;
        $display("FAIL load_midperiod k=%0d: got clk %b tick %b expected clk %b tick %b",
                 k, bus.clk_out, bus.tick_out, exp_clk, exp_tick);
      end
    end
  endtask

  task automatic test_clamp();
    logic [1:0] exp_clk, exp_tick;
    do_reset();
    reset_n              = 1'b1;
    bus.div_load         = 2'b10;
    bus.div_in[CW +: CW] = 17'd0;
    step();
    bus.div_load = 2'b00;
    bus.en       = 2'b10;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) begin
        bus.div_load         = 2'b10;
        bus.div_in[CW +: CW] = 17'd1;
      end else begin
        bus.div_load = 2'b00;
      end
      step();
      exp_clk  = ((k % 2) == 0) ? 2'b10 : 2'b00;
      exp_tick = ((k % 2) == 0) ? 2'b10 : 2'b00;
      checks++;
      if (bus.clk_out !== exp_clk || bus.tick_out !== exp_tick) begin
        errors++;
        $display("FAIL clamp_div k=%0d: got clk %b tick %b expected clk %b tick %b",
                 k, bus.clk_out, bus.tick_out, exp_clk, exp_tick);
      end
    end
  endtask

  task automatic test_sync();
    logic [1:0] exp_clk, exp_tick;
    do_reset();
    reset_n      = 1'b1;
    bus.div_load = 2'b11;
    bus.div_in   = {17'd7, 17'd4};
    step();
    bus.div_load = 2'b00;
    for (int g = 0; g < 25; g++) begin
      bus.en   = (g < 3) ? 2'b01 : 2'b11;
      bus.sync = (g == 10);
      step();
      if (g == 9) begin
        checks++;
        if (bus.clk_out !== 2'b01) begin
          errors++;
          $display("FAIL sync_prephase: got clk %b expected %b", bus.clk_out, 2'b01);
        end
      end
      if (g >= 10) begin
        exp_clk  = {(((g - 10) % 7) < 4), (((g - 10) % 4) < 2)};
        exp_tick = {(((g - 10) % 7) == 0), (((g - 10) % 4) == 0)};
        checks++;
        if (bus.clk_out !== exp_clk || bus.tick_out !== exp_tick) begin
          errors++;
          $display("FAIL sync_align g=%0d: got clk %b tick %b expected clk %b tick %b",
                   g, bus.clk_out, bus.tick_out, exp_clk, exp_tick);
        end
      end
    end
    bus.sync = 1'b0;
  endtask

  task automatic test_bypass();
    logic [1:0] exp_clk, exp_tick;
    do_reset();
    reset_n = 1'b1;
    bus.en  = 2'b01;
    for (int g = 0; g < 46; g++) begin
      if (g == 26) begin
        bus.div_load        = 2'b01;
        bus.div_in[0 +: CW] = 17'd10;
      end else begin
        bus.div_load = 2'b00;
      end
      step();
      if (g >= 20) begin
        if (g < 26) begin
          exp_clk  = 2'b00;
          exp_tick = 2'b00;
        end else begin
          exp_clk  = {1'b0, (((g - 26) % 10) < 5)};
          exp_tick = {1'b0, (((g - 26) % 10) == 0)};
        end
        checks++;
        if (bus.clk_out !== exp_clk || bus.tick_out !== exp_tick) begin
          errors++;
          $display("FAIL load_on_wrap g=%0d: got clk %b tick %b expected clk %b tick %b",
                   g, bus.clk_out, bus.tick_out, exp_clk, exp_tick);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_clk, exp_tick;
    do_reset();
    reset_n = 1'b1;
    bus.en  = 2'b01;
    for (int g = 0; g < 41; g++) begin
      reset_n = (g == 5) ? 1'b0 : 1'b1;
      if (g == 3) begin
        bus.div_load        = 2'b01;
        bus.div_in[0 +: CW] = 17'd6;
      end else begin
        bus.div_load = 2'b00;
      end
      step();
      if (g == 5) begin
        checks++;
        if (bus.clk_out !== 2'b00 || bus.tick_out !== 2'b00) begin
          errors++;
          $display("FAIL reset_mid: got clk %b tick %b expected 00 00", bus.clk_out, bus.tick_out);
        end
      end else if (g >= 6) begin
        exp_clk  = {1'b0, (((g - 6) % 26) < 13)};
        exp_tick = {1'b0, (((g - 6) % 26) == 0)};
        checks++;
        if (bus.clk_out !== exp_clk || bus.tick_out !== exp_tick) begin
          errors++;
          $display("FAIL reset_drops_pend g=%0d: got clk %b tick %b expected clk %b tick %b",
                   g, bus.clk_out, bus.tick_out, exp_clk, exp_tick);
        end
      end
    end
  endtask

  task automatic test_disable();
    do_reset();
    reset_n = 1'b1;
    for (int g = 0; g < 12; g++) begin
      bus.en   = (g >= 3 && g < 10) ? 2'b00 : 2'b01;
      bus.sync = (g == 5);
      step();
      if (g >= 3 && g < 10) begin
        checks++;
        if (bus.clk_out !== 2'b00 || bus.tick_out !== 2'b00) begin
          errors++;
          $display("FAIL disabled_hold g=%0d: got clk %b tick %b expected 00 00",
                   g, bus.clk_out, bus.tick_out);
        end
      end else if (g == 10) begin
        checks++;
        if (bus.clk_out !== 2'b01 || bus.tick_out !== 2'b01) begin
          errors++;
          $display("FAIL reenable_rise: got clk %b tick %b expected 01 01", bus.clk_out, bus.tick_out);
        end
      end
    end
    bus.sync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_load_midperiod();
    test_clamp();
    test_sync();
    test_bypass();
    test_reset_mid();
    test_disable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
